bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

MM:SS countdown timer that decrements a four-digit BCD value by one second per input tick, borrowing from digit to digit. It is the down-counting counterpart of the up-counting, carry-chained clock digits. It takes the same tick enable that drives the clock chain and presents its value on the same display path. It supports load, start, pause and resume, and flags expiry with a one-cycle pulse plus a level.

## Interface
- N, 4, BCD digit width; fixed at 4, present for consistency with the digit counters.
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- tick  input  1  one-cycle enable, one second elapsed; at most one decrement per asserted cycle.
- load  input  1  load setValue into the timer; forces IDLE.
- setValue  input  4*N (16)  {min tens, min units, sec tens, sec units} in BCD.
- start  input  1  level-sampled; begin or resume counting.
- pause  input  1  level-sampled; suspend counting.
- q  output  4*N (16)  current value {MT, MU, ST, SU} in BCD.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done  output  1  one-cycle pulse on reaching 00:00 from RUN.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Reset state is IDLE.
- Per-cycle priority: reset > load > pause > start > tick.
- reset: q=0000, running=0, expired=0, done=0, state IDLE. Applies mid-count with no residual done.
- load, any state: q is set from setValue with sanitizing, and state goes to IDLE.
  - Sanitizing: MT, MU or SU >9 loads as 9; ST >5 loads as 5.
  - Range is 00:00..99:59.
- start:
  - In IDLE or PAUSED with q≠0000, go to RUN.
  - With q=0000, start is ignored and no done is produced.
  - Ignored in RUN and EXPIRED.
- pause: in RUN, go to PAUSED. Ignored in other states.
- tick in RUN: q decrements by one second.
  - SU 0→9 with borrow to ST.
  - ST 0→5 with borrow to MU.
  - MU 0→9 with borrow to MT.
  - Example: 10:00→09:59.
- tick in RUN with q=00:01: q becomes 0000 and state goes to EXPIRED.
- tick outside RUN: no effect. No decrement below 0000 and no wrap.
- EXPIRED is left only by load (to IDLE) or reset.
- q never holds a non-BCD digit or ST>5.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Decrement latency: q updates on the edge that samples tick=1; the new value is visible the next cycle.
- done: high for exactly one cycle, the cycle in which q first reads 0000 and expired first reads 1.
- running follows state with no extra delay: high the cycle after the start edge, low the cycle after the pause, load, expiry or reset edge.
- Simultaneous events:
  - start+tick in IDLE or PAUSED: enter RUN, no decrement that cycle.
  - pause+tick in RUN: PAUSED, no decrement.
  - pause+start in RUN: PAUSED.
  - load+tick, or load+start: load only, state IDLE.
  - reset overrides everything.
- Back-to-back ticks on consecutive cycles each decrement once.

## Test plan
- Reset, then load 0x0100, start, one tick -> q=0x0059, running=1, done=0.
- Load 0x0002, start, two ticks -> q=0x0001, then q=0x0000 with done=1 for one cycle, expired=1, running=0.
  - A further tick and start -> q stays 0x0000 and done stays 0.
- Load 0x1000, start, 3 ticks, pause, 2 ticks, start, 1 tick -> q goes 0959, 0958, 0957, holds 0957, then 0956.
  - pause+tick in the same cycle -> no decrement.
- Load 0xFFFF -> q=0x9959.
  - Load 0x0000 then start -> state stays IDLE, done=0.
  - Load 0x0A7C -> q=0x0959.
- From RUN at 0x0530, assert reset mid-count -> next cycle q=0x0000, running=0, expired=0, done=0.
  - Start then -> ignored.
- Load 0x0001, start, then tick+load(0x0200) in the same cycle -> q=0x0200, state IDLE, done=0.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : MM:SS BCD countdown timer with load/start/pause and expiry flags.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [4*N-1:0]   setValue,
    input  logic             start,
    input  logic             pause,
    output logic [4*N-1:0]   q,
    output logic             running,
    output logic             expired,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4*N-1:0]  r_q;
    logic [4*N-1:0]  w_q_nxt;
    logic            r_done;
    logic            w_done_nxt;

    logic [N-1:0]    w_mt, w_mu, w_st, w_su;
    logic [N-1:0]    w_ld_mt, w_ld_mu, w_ld_st, w_ld_su;
    logic [4*N-1:0]  w_q_dec;
    logic            w_q_zero;

    assign w_mt = r_q[4*N-1:3*N];
    assign w_mu = r_q[3*N-1:2*N];
    assign w_st = r_q[2*N-1:N];
    assign w_su = r_q[N-1:0];

    // Out-of-range digits clamp to their maximum so q always stays valid BCD.
    assign w_ld_mt = (setValue[4*N-1:3*N] > 4'd9) ? 4'd9 : setValue[4*N-1:3*N];
    assign w_ld_mu = (setValue[3*N-1:2*N] > 4'd9) ? 4'd9 : setValue[3*N-1:2*N];
    assign w_ld_st = (setValue[2*N-1:N]   > 4'd5) ? 4'd5 : setValue[2*N-1:N];
    assign w_ld_su = (setValue[N-1:0]     > 4'd9) ? 4'd9 : setValue[N-1:0];

    assign w_q_zero = (r_q == '0);

    // Borrow chain; only evaluated in RUN where q is never zero.
    always_comb begin
        logic b_st, b_mu, b_mt;
        logic [N-1:0] n_mt, n_mu, n_st, n_su;
        b_st = (w_su == 4'd0);
        b_mu = b_st && (w_st == 4'd0);
        b_mt = b_mu && (w_mu == 4'd0);
        n_su = (w_su == 4'd0) ? 4'd9 : w_su - 4'd1;
        n_st = b_st ? ((w_st == 4'd0) ? 4'd5 : w_st - 4'd1) : w_st;
        n_mu = b_mu ? ((w_mu == 4'd0) ? 4'd9 : w_mu - 4'd1) : w_mu;
        n_mt = b_mt ? ((w_mt == 4'd0) ? 4'd0 : w_mt - 4'd1) : w_mt;
        w_q_dec = {n_mt, n_mu, n_st, n_su};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_q_nxt     = {w_ld_mt, w_ld_mu, w_ld_st, w_ld_su};
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSED: begin
                    if (start && !w_q_zero) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (tick) begin
                        w_q_nxt = w_q_dec;
                        if (w_q_dec == '0) begin
                            w_state_nxt = S_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    w_state_nxt = S_EXPIRED;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q       = r_q;
    assign running = (r_state == S_RUN);
    assign expired = (r_state == S_EXPIRED);
    assign done    = r_done;

endmodule
`default_nettype wire
